fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end for the MCU32X core, replacing free-running PC-increment fetch. Owns the fetch PC and issues word-aligned requests to instruction memory over a valid/ready handshake. Buffers returned instructions with their PCs in a small queue, and presents them to decode over valid/ready. Supports branch/jump redirect with queue flush and stale-response discard, and halts on memory access fault.

---
 rtl/fetch_queue_unit_pkg.sv | 28 ++
 rtl/fetch_queue_unit_fifo.sv | 57 +++++
 rtl/fetch_queue_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// mcu32x_fetch_pkg: shared types and constants for the MCU32X fetch front end.
//   fetch_state_t : fetch FSM state encoding
//   INSTR_W       : instruction word width
//   PC_INC        : fetch stride in bytes (one 32-bit word)
//   fetch_entry_t : queue entry {pc, instr, fault} at the default 32-bit PC
//                   width. The unit itself rebuilds the same layout at its
//                   XLEN parameter.
package mcu32x_fetch_pkg;

  localparam int INSTR_W      = 32;
  localparam int PC_INC       = 4;
  localparam int PC_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,   // waiting for queue space
    REQ,    // request presented to imem
    WAIT,   // one request outstanding, response will be queued
    DRAIN,  // one stale request outstanding, response will be dropped
    HALT    // access fault seen, only a redirect restarts fetch
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]      instr;
    logic                    fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo: synchronous FIFO used as the fetch instruction queue.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   push, push_data : write an entry (ignored when full)
//   pop             : retire the head entry (ignored when empty)
//   flush           : drop every entry; wins over push and pop
//   head_data       : current head entry (undefined when empty)
//   full, empty     : status
//   count           : number of stored entries
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end for the MCU32X core.
// Owns the fetch PC, issues one word-aligned request at a time to imem,
// queues returned words with their PCs and hands them to decode.
//   clk, reset                     : clock, synchronous active-high reset
//   redirect_valid, redirect_pc    : taken branch/jump; flush and refetch
//   imem_req_valid/ready/addr      : request channel (addr = fetch_pc)
//   imem_resp_valid/data/error     : one response per accepted request
//   inst_valid/ready/data/pc/fault : queue head toward decode
//   occupancy                      : number of queued entries
module fetch_queue_unit
  import mcu32x_fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             redirect_valid,
  input  logic [XLEN-1:0]                  redirect_pc,
  output logic                             imem_req_valid,
  input  logic                             imem_req_ready,
  output logic [XLEN-1:0]                  imem_req_addr,
  input  logic                             imem_resp_valid,
  input  logic [INSTR_W-1:0]               imem_resp_data,
  input  logic                             imem_resp_error,
  output logic                             inst_valid,
  input  logic                             inst_ready,
  output logic [INSTR_W-1:0]               inst_data,
  output logic [XLEN-1:0]                  inst_pc,
  output logic                             inst_fault,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(QUEUE_DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } entry_t;

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] req_pc;     // address of the outstanding request
  logic [XLEN-1:0] redir_pc;

  entry_t          q_in, q_head;
  logic            q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]   occ;
  logic [CW:0]     occ_after;
  logic            in_flight;

  // Redirect flushes the queue, so neither a push nor a pop may land on the
  // same cycle: a same-cycle response belongs to the old path.
  assign q_push = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign q_pop  = !q_empty && inst_ready && !redirect_valid;
  assign q_in   = '{pc: req_pc, instr: imem_resp_data, fault: imem_resp_error};

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (occ)
  );

  // Queue level once this cycle's push/pop settle; decides whether another
  // request still fits after the one just returned.
  assign occ_after = {1'b0, occ} + (CW+1)'(q_push) - (CW+1)'(q_pop);

  // Low two bits of redirect_pc are dropped to keep fetch word aligned.
  assign redir_pc = redirect_pc & ~(XLEN'(PC_INC - 1));

  // After this edge, is there still a request whose response has not come
  // back? If so a redirect must go through DRAIN to swallow it. A response
  // arriving on the redirect cycle itself is the stale one, already dropped.
  assign in_flight = (((state == WAIT) || (state == DRAIN)) && !imem_resp_valid)
                  || ((state == REQ) && imem_req_ready);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    case (state)
      // Entering IDLE means nothing is outstanding, so the full flag alone
      // is the space check.
      IDLE:  if (!q_full) state_n = REQ;
      REQ: begin
        if (imem_req_ready) begin
          fetch_pc_n = fetch_pc + XLEN'(PC_INC);
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_error)                            state_n = HALT;
          else if (occ_after < (CW+1)'(QUEUE_DEPTH))      state_n = REQ;
          else                                            state_n = IDLE;
        end
      end
      DRAIN: if (imem_resp_valid) state_n = REQ;
      HALT:  state_n = HALT;
      default: state_n = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_n = redir_pc;
      state_n    = in_flight ? DRAIN : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if ((state == REQ) && imem_req_ready) req_pc <= fetch_pc;
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = fetch_pc;

  // Head fields are masked so an empty queue always reads as zero.
  assign inst_valid = !q_empty;
  assign inst_data  = inst_valid ? q_head.instr : '0;
  assign inst_pc    = inst_valid ? q_head.pc    : '0;
  assign inst_fault = inst_valid && q_head.fault;
  assign occupancy  = occ;

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
  import mcu32x_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_error;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h100), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_error(imem_resp_error),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_fault(inst_fault), .occupancy(occupancy)
  );

  int           total = 0;
  int           bad   = 0;
  int           req_cnt = 0;
  int           lat = 1;
  logic         err_en = 1'b0;
  logic [31:0]  err_addr = '0;
  logic [31:0]  resp_addr;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  // Memory contents: upper half = address, lower half = its complement.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic f);
    fetch_entry_t e;
    e.pc = pc; e.instr = mem_fn(pc); e.fault = f;
    exp_q.push_back(e);
  endtask

  // Memory model: one outstanding request, response after lat cycles.
  initial begin
    imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_error = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        resp_addr = imem_req_addr;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_fn(resp_addr);
        imem_resp_error = err_en && (resp_addr == err_addr);
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_error = 1'b0;
      end
    end
  end

  // Accepted-request counter.
  initial forever begin
    @(negedge clk);
    if (!reset && imem_req_valid && imem_req_ready) req_cnt++;
  end

  // Scoreboard monitor: every consumed head is compared to the next expectation.
  initial forever begin
    @(negedge clk);
    if (!reset && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_inst: got pc %h want none", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("inst_pc",    inst_pc,    mon_e.pc);
        chk("inst_data",  inst_data,  mon_e.instr);
        chk("inst_fault", inst_fault, mon_e.fault);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Let exactly n requests be accepted, then drop ready.
  task automatic issue(input int n);
    int c;
    c = 0;
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        c++;
        if (c == n) begin
          @(posedge clk); #1;
          imem_req_ready = 1'b0;
          return;
        end
      end
    end
    imem_req_ready = 1'b0;
    total++; bad++;
    $display("FAIL issue_timeout: got %0d want %0d", c, n);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    total++; bad++;
    $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
  endtask

  task automatic wait_req_valid();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_req_valid) return;
    end
    total++; bad++;
    $display("FAIL req_timeout: got req_valid 0 want 1");
  endtask

  task automatic pulse_pop();
    @(posedge clk); #1; inst_ready = 1'b1;
    @(posedge clk); #1; inst_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = pc;
    @(posedge clk); #1; redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; inst_ready = 1'b1;

    // Reset values and in-order delivery from RESET_PC.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr",  imem_req_addr,  32'h100);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc",   inst_pc, 0);
    chk("rst_inst_fault", inst_fault, 0);
    chk("rst_occupancy", occupancy, 0);
    push_exp(32'h100, 1'b0); push_exp(32'h104, 1'b0); push_exp(32'h108, 1'b0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("first_cycle_idle", imem_req_valid, 0);
    @(negedge clk);
    chk("second_cycle_req", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    issue(3);
    wait_drain();

    // Backpressure: queue fills, requests stop, one pop buys one request.
    @(posedge clk); #1;
    inst_ready = 1'b0;
    push_exp(32'h10C, 1'b0); push_exp(32'h110, 1'b0);
    push_exp(32'h114, 1'b0); push_exp(32'h118, 1'b0);
    req_cnt = 0; imem_req_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("full_req_cnt", req_cnt, 4);
    chk("full_occupancy", occupancy, 4);
    chk("full_req_valid", imem_req_valid, 0);
    push_exp(32'h11C, 1'b0);
    pulse_pop();
    repeat (10) @(negedge clk);
    chk("pop_req_cnt", req_cnt, 5);
    chk("pop_occupancy", occupancy, 4);

    // Redirect in WAIT with a non-empty queue: flush plus stale-response drop.
    lat = 3;
    pulse_pop();
    wait_req_valid();
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    exp_q.delete();
    push_exp(32'h200, 1'b0); push_exp(32'h204, 1'b0);
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_inst_valid", inst_valid, 0);
    chk("redir_occupancy", occupancy, 0);
    chk("drain_req_valid", imem_req_valid, 0);
    @(posedge clk); #1; inst_ready = 1'b1; lat = 1;
    wait_req_valid();
    chk("redir_req_addr", imem_req_addr, 32'h200);
    issue(2);
    wait_drain();

    // Access fault at 0x10C: delivered with fault, then fetch halts.
    err_en = 1'b1; err_addr = 32'h10C;
    push_exp(32'h104, 1'b0); push_exp(32'h108, 1'b0); push_exp(32'h10C, 1'b1);
    redirect(32'h104);
    req_cnt = 0; imem_req_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("halt_req_cnt", req_cnt, 3);
    chk("halt_req_valid", imem_req_valid, 0);
    wait_drain();
    chk("halt_empty_req_valid", imem_req_valid, 0);
    @(posedge clk); #1; imem_req_ready = 1'b0; err_en = 1'b0;
    push_exp(32'h0, 1'b0); push_exp(32'h4, 1'b0);
    redirect(32'h0);
    @(negedge clk);
    chk("resume_req_valid", imem_req_valid, 1);
    chk("resume_req_addr", imem_req_addr, 32'h0);
    issue(2);
    wait_drain();

    // PC wrap; low redirect bits ignored.
    push_exp(32'hFFFF_FFFC, 1'b0); push_exp(32'h0, 1'b0);
    redirect(32'hFFFF_FFFE);
    @(negedge clk);
    chk("wrap_start_addr", imem_req_addr, 32'hFFFF_FFFC);
    issue(2);
    wait_drain();
    chk("wrap_next_addr", imem_req_addr, 32'h4);

    // Reset mid-WAIT with three entries queued; the late response is ignored.
    @(posedge clk); #1; inst_ready = 1'b0;
    issue(3);
    repeat (4) @(negedge clk);
    chk("pre_rst_occupancy", occupancy, 3);
    lat = 4;
    issue(1);
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_inst_valid", inst_valid, 0);
    chk("mid_rst_req_valid", imem_req_valid, 0);
    lat = 1;
    repeat (8) @(negedge clk);
    chk("late_resp_occupancy", occupancy, 0);
    chk("late_resp_inst_valid", inst_valid, 0);
    push_exp(32'h100, 1'b0);
    @(posedge clk); #1; inst_ready = 1'b1;
    issue(1);
    wait_drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
